// File: rtl/irq_vec_ctl.sv
// irq_vec_ctl: interrupt controller for the 65C02 core.
// Up to 16 level/edge IRQ channels with fixed lowest-index priority. The block
// substitutes the IRQ vector during the $FFFE/$FFFF fetch, latches an NMI edge,
// and exposes an 8-byte register window on the CPU bus.
module irq_vec_ctl #(
  parameter int unsigned CHANNELS = 8,
  parameter logic [15:0] BASE     = 16'hFE00,
  parameter logic [7:0]  VEC_HI   = 8'hFF
) (
  input  logic                clk,
  input  logic                RST,
  input  logic [15:0]         AD,
  input  logic [7:0]          DI,
  input  logic                WE,
  output logic [7:0]          DO,
  output logic                DOE,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic                nmi_in,
  output logic                IRQ,
  output logic                NMI
);

  // Bits at or above CHANNELS are never stored, so they read 0 and ignore writes.
  localparam logic [15:0] ChMask   = 16'((32'd1 << CHANNELS) - 32'd1);
  localparam logic [15:0] AddrVecL = 16'hFFFE;
  localparam logic [15:0] AddrVecH = 16'hFFFF;
  localparam logic [15:0] AddrNmiL = 16'hFFFA;

  logic [15:0] irq_pad;
  logic [15:0] irq_s1_q, irq_s2_q, irq_s3_q;
  logic        nmi_s1_q, nmi_s2_q, nmi_s3_q;

  logic [15:0] pend_q, pend_d;
  logic [15:0] en_q, en_d;
  logic [15:0] edge_q, edge_d;
  logic [7:0]  veclo_q, veclo_d;
  logic        nmi_p_q, nmi_p_d;
  logic        hit_q;

  logic        win;
  logic        wr_win;
  logic [15:0] clr;
  logic [15:0] rise;
  logic [15:0] active;
  logic        act_any;
  logic [3:0]  act_idx;
  logic [7:0]  vec_lo;
  logic [7:0]  rd_data;
  logic        nmi_rise;
  logic        nmi_clr;

  assign irq_pad = 16'(irq_in);

  // Next-state for pending/config registers, priority encode and read mux
  always_comb begin
    win    = (AD[15:3] == BASE[15:3]);
    wr_win = WE && win;

    clr = '0;
    if (wr_win && (AD[2:0] == 3'd0)) clr[7:0]  = DI;
    if (wr_win && (AD[2:0] == 3'd1)) clr[15:8] = DI;

    // Edge channels latch a rising edge (set beats clear); level channels track s2.
    rise   = irq_s2_q & ~irq_s3_q;
    pend_d = ((edge_q & ((pend_q & ~clr) | rise)) | (~edge_q & irq_s2_q)) & ChMask;

    en_d    = en_q;
    edge_d  = edge_q;
    veclo_d = veclo_q;
    if (wr_win) begin
      case (AD[2:0])
        3'd2:    en_d[7:0]    = DI;
        3'd3:    en_d[15:8]   = DI;
        3'd4:    edge_d[7:0]  = DI;
        3'd5:    edge_d[15:8] = DI;
        3'd7:    veclo_d      = {DI[7:1], 1'b0};
        default: ;
      endcase
    end
    en_d   = en_d & ChMask;
    edge_d = edge_d & ChMask;

    // Lowest enabled pending index wins; scan downwards so the last hit is lowest.
    active  = pend_q & en_q;
    act_any = |active;
    act_idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (active[i]) act_idx = 4'(i);
    end
    vec_lo = veclo_q + {3'b000, act_idx, 1'b0};

    rd_data = '0;
    unique case (AD[2:0])
      3'd0: rd_data = pend_q[7:0];
      3'd1: rd_data = pend_q[15:8];
      3'd2: rd_data = en_q[7:0];
      3'd3: rd_data = en_q[15:8];
      3'd4: rd_data = edge_q[7:0];
      3'd5: rd_data = edge_q[15:8];
      3'd6: rd_data = act_any ? {4'b0000, act_idx} : 8'h80;
      3'd7: rd_data = veclo_q;
    endcase

    nmi_rise = nmi_s2_q & ~nmi_s3_q;
    nmi_clr  = !WE && (AD == AddrNmiL);
    nmi_p_d  = (nmi_p_q & ~nmi_clr) | nmi_rise;
  end

  // Two-flop synchronisers plus a history flop for edge detection
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      irq_s1_q <= '0;
      irq_s2_q <= '0;
      irq_s3_q <= '0;
      nmi_s1_q <= 1'b0;
      nmi_s2_q <= 1'b0;
      nmi_s3_q <= 1'b0;
    end else begin
      irq_s1_q <= irq_pad & ChMask;
      irq_s2_q <= irq_s1_q;
      irq_s3_q <= irq_s2_q;
      nmi_s1_q <= nmi_in;
      nmi_s2_q <= nmi_s1_q;
      nmi_s3_q <= nmi_s2_q;
    end
  end

  // Pending, configuration and request registers
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      pend_q  <= '0;
      en_q    <= '0;
      edge_q  <= '0;
      veclo_q <= '0;
      nmi_p_q <= 1'b0;
      IRQ     <= 1'b0;
      NMI     <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      en_q    <= en_d;
      edge_q  <= edge_d;
      veclo_q <= veclo_d;
      nmi_p_q <= nmi_p_d;
      IRQ     <= act_any;
      NMI     <= nmi_p_q;
    end
  end

  // Registered bus read port: register window and vector substitution
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      DO    <= '0;
      DOE   <= 1'b0;
      hit_q <= 1'b0;
    end else if (WE) begin
      DO  <= '0;
      DOE <= 1'b0;
    end else if (win) begin
      DO  <= rd_data;
      DOE <= 1'b1;
    end else if (AD == AddrVecL) begin
      // The high byte is constant, so only the hit decision must persist to $FFFF.
      hit_q <= act_any;
      DOE   <= act_any;
      DO    <= act_any ? vec_lo : 8'h00;
    end else if (AD == AddrVecH) begin
      DOE <= hit_q;
      DO  <= hit_q ? VEC_HI : 8'h00;
    end else begin
      DO  <= '0;
      DOE <= 1'b0;
    end
  end

endmodule

// File: tb/tb_irq_vec_ctl.sv
// Testbench for irq_vec_ctl: directed scenarios then random traffic, all
// checked every cycle against a cycle-level behavioural model.
module tb_irq_vec_ctl;

  localparam int unsigned CH     = 10;
  localparam logic [15:0] BASE   = 16'hFE00;
  localparam logic [15:0] IDLE_A = 16'h1234;

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   ad;
  logic [7:0]    di;
  logic          we;
  logic [7:0]    dout;
  logic          doe;
  logic [CH-1:0] irq_in;
  logic          nmi_in;
  logic          irq;
  logic          nmi;

  int n_vec = 0;
  int n_err = 0;

  // Model state: input samples seen 1/2/3 edges ago, architectural registers.
  logic [15:0] in_d1, in_d2, in_d3;
  logic        nd1, nd2, nd3;
  logic [15:0] m_p, m_en, m_edge;
  logic [7:0]  m_veclo;
  logic        m_hit, m_nmi_p;
  logic [7:0]  e_do;
  logic        e_doe, e_irq, e_nmi;

  always #5 clk = ~clk;

  irq_vec_ctl #(
    .CHANNELS(CH),
    .BASE    (BASE),
    .VEC_HI  (8'hFF)
  ) dut (
    .clk   (clk),
    .RST   (rst),
    .AD    (ad),
    .DI    (di),
    .WE    (we),
    .DO    (dout),
    .DOE   (doe),
    .irq_in(irq_in),
    .nmi_in(nmi_in),
    .IRQ   (irq),
    .NMI   (nmi)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_active();
    for (int i = 0; i < int'(CH); i++) begin
      if (m_p[i] && m_en[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    in_d1 = '0; in_d2 = '0; in_d3 = '0;
    nd1 = 0; nd2 = 0; nd3 = 0;
    m_p = '0; m_en = '0; m_edge = '0; m_veclo = '0;
    m_hit = 0; m_nmi_p = 0;
    e_do = '0; e_doe = 0; e_irq = 0; e_nmi = 0;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int          a;
    int          off;
    bit          win;
    bit          clr;
    logic [15:0] inw;
    a   = first_active();
    win = (ad[15:3] == BASE[15:3]);
    off = int'(ad[2:0]);
    inw = 16'(irq_in);

    if (we) begin
      e_do = 0; e_doe = 0;
    end else if (win) begin
      e_doe = 1;
      case (off)
        0: e_do = m_p[7:0];
        1: e_do = m_p[15:8];
        2: e_do = m_en[7:0];
        3: e_do = m_en[15:8];
        4: e_do = m_edge[7:0];
        5: e_do = m_edge[15:8];
        6: e_do = (a >= 0) ? 8'(a) : 8'h80;
        default: e_do = m_veclo;
      endcase
    end else if (ad == 16'hFFFE) begin
      m_hit = (a >= 0);
      e_doe = m_hit;
      e_do  = m_hit ? 8'(int'(m_veclo) + 2 * a) : 8'h00;
    end else if (ad == 16'hFFFF) begin
      e_doe = m_hit;
      e_do  = m_hit ? 8'hFF : 8'h00;
    end else begin
      e_do = 0; e_doe = 0;
    end
    e_irq = (a >= 0);
    e_nmi = m_nmi_p;

    for (int i = 0; i < int'(CH); i++) begin
      if (m_edge[i]) begin
        clr = we && win && ((off == 0 && i < 8 && di[i % 8]) || (off == 1 && i >= 8 && di[i % 8]));
        m_p[i] = (m_p[i] && !clr) || (in_d2[i] && !in_d3[i]);
      end else begin
        m_p[i] = in_d2[i];
      end
    end
    m_nmi_p = (m_nmi_p && !(!we && ad == 16'hFFFA)) || (nd2 && !nd3);

    if (we && win) begin
      for (int i = 0; i < int'(CH); i++) begin
        if (off == 2 && i < 8)  m_en[i]   = di[i % 8];
        if (off == 3 && i >= 8) m_en[i]   = di[i % 8];
        if (off == 4 && i < 8)  m_edge[i] = di[i % 8];
        if (off == 5 && i >= 8) m_edge[i] = di[i % 8];
      end
      if (off == 7) m_veclo = di & 8'hFE;
    end

    in_d3 = in_d2; in_d2 = in_d1; in_d1 = inw;
    nd3 = nd2; nd2 = nd1; nd1 = nmi_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("do", dout, e_do);
    chk("doe", {7'b0, doe}, {7'b0, e_doe});
    chk("irq", {7'b0, irq}, {7'b0, e_irq});
    chk("nmi", {7'b0, nmi}, {7'b0, e_nmi});
  endtask

  task automatic bus(input logic [15:0] a, input logic w, input logic [7:0] d);
    ad = a; we = w; di = d;
    step();
    ad = IDLE_A; we = 1'b0; di = 8'h00;
  endtask

  task automatic rd(input logic [15:0] a);
    bus(a, 1'b0, 8'h00);
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus(a, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_do", dout, 8'h00);
    chk("rst_doe", {7'b0, doe}, 8'h00);
    chk("rst_irq", {7'b0, irq}, 8'h00);
    chk("rst_nmi", {7'b0, nmi}, 8'h00);
    model_reset();
    #1 rst = 1'b0;
  endtask

  initial begin
    int op;
    rst = 1'b1; ad = IDLE_A; we = 1'b0; di = 8'h00; irq_in = '0; nmi_in = 1'b0;
    model_reset();
    #1;
    chk("reset_do", dout, 8'h00);
    chk("reset_doe", {7'b0, doe}, 8'h00);
    chk("reset_irq", {7'b0, irq}, 8'h00);
    chk("reset_nmi", {7'b0, nmi}, 8'h00);
    #11 rst = 1'b0;

    // Level channel 2
    wr(BASE + 16'd2, 8'h04);
    irq_in[2] = 1'b1;
    idle(3);
    chk("lvl_irq_k2", {7'b0, irq}, 8'h00);
    idle(1);
    chk("lvl_irq_k3", {7'b0, irq}, 8'h01);
    rd(BASE + 16'd6);
    chk("lvl_active", dout, 8'h02);
    irq_in[2] = 1'b0;
    idle(4);
    chk("lvl_irq_drop", {7'b0, irq}, 8'h00);

    // Edge channel 0: latch, clear, set-wins-over-clear
    wr(BASE + 16'd4, 8'h01);
    wr(BASE + 16'd2, 8'h01);
    irq_in[0] = 1'b1;
    step();
    irq_in[0] = 1'b0;
    idle(4);
    rd(BASE + 16'd0);
    chk("edge_pend", dout, 8'h01);
    chk("edge_irq_held", {7'b0, irq}, 8'h01);
    wr(BASE + 16'd0, 8'h01);
    step();
    chk("edge_irq_cleared", {7'b0, irq}, 8'h00);
    irq_in[0] = 1'b1;
    step();
    irq_in[0] = 1'b0;
    step();
    wr(BASE + 16'd0, 8'h01);
    step();
    chk("edge_set_wins", {7'b0, irq}, 8'h01);
    wr(BASE + 16'd0, 8'h01);
    idle(2);

    // Priority and vector substitution
    wr(BASE + 16'd7, 8'h41);
    wr(BASE + 16'd4, 8'h28);
    wr(BASE + 16'd2, 8'h28);
    irq_in[3] = 1'b1; irq_in[5] = 1'b1;
    step();
    irq_in[3] = 1'b0; irq_in[5] = 1'b0;
    idle(4);
    rd(16'hFFFE);
    chk("vec_lo", dout, 8'h46);
    chk("vec_lo_doe", {7'b0, doe}, 8'h01);
    wr(BASE + 16'd0, 8'h08);
    rd(16'hFFFF);
    chk("vec_hi", dout, 8'hFF);
    chk("vec_hi_doe", {7'b0, doe}, 8'h01);
    rd(16'hFFFE);
    chk("vec_lo_next", dout, 8'h4A);
    wr(BASE + 16'd0, 8'h20);
    idle(2);

    // No hit, and a pending but disabled channel
    rd(16'hFFFE);
    chk("nohit_lo_doe", {7'b0, doe}, 8'h00);
    rd(16'hFFFF);
    chk("nohit_hi_doe", {7'b0, doe}, 8'h00);
    irq_in[1] = 1'b1;
    idle(4);
    rd(BASE + 16'd6);
    chk("active_none", dout, 8'h80);
    irq_in[1] = 1'b0;
    idle(3);

    // NMI edge latch and clear
    nmi_in = 1'b1;
    idle(3);
    chk("nmi_k2", {7'b0, nmi}, 8'h00);
    idle(1);
    chk("nmi_set", {7'b0, nmi}, 8'h01);
    rd(16'hFFFA);
    chk("nmi_fffa_doe", {7'b0, doe}, 8'h00);
    step();
    chk("nmi_cleared", {7'b0, nmi}, 8'h00);
    idle(3);
    chk("nmi_held_no_edge", {7'b0, nmi}, 8'h00);
    nmi_in = 1'b0;
    idle(2);
    nmi_in = 1'b1;
    idle(4);
    chk("nmi_second", {7'b0, nmi}, 8'h01);
    rd(16'hFFFA);
    idle(2);

    // Reset between the two vector bytes
    wr(BASE + 16'd4, 8'h01);
    wr(BASE + 16'd2, 8'h01);
    irq_in[0] = 1'b1;
    idle(4);
    chk("pre_rst_irq", {7'b0, irq}, 8'h01);
    rd(16'hFFFE);
    chk("pre_rst_doe", {7'b0, doe}, 8'h01);
    pulse_reset();
    rd(16'hFFFF);
    chk("post_rst_hi_doe", {7'b0, doe}, 8'h00);

    // Input high through reset release counts as an edge
    pulse_reset();
    wr(BASE + 16'd4, 8'h01);
    wr(BASE + 16'd2, 8'h01);
    step();
    chk("rel_irq_e3", {7'b0, irq}, 8'h00);
    step();
    chk("rel_irq_e4", {7'b0, irq}, 8'h01);
    irq_in[0] = 1'b0;
    nmi_in = 1'b0;

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < int'(CH); i++) begin
        if ($urandom_range(7) == 0) irq_in[i] = ~irq_in[i];
      end
      if ($urandom_range(9) == 0) nmi_in = ~nmi_in;
      op = int'($urandom_range(9));
      di = 8'($urandom);
      case (op)
        0, 1: begin ad = BASE | 16'($urandom_range(7)); we = 1'b0; end
        2, 3: begin ad = BASE | 16'($urandom_range(7)); we = 1'b1; end
        4:    begin ad = 16'hFFFE; we = 1'b0; end
        5:    begin ad = 16'hFFFF; we = 1'b0; end
        6:    begin ad = 16'hFFFA; we = 1'b0; end
        7:    begin ad = 16'($urandom); we = 1'($urandom); end
        default: begin ad = IDLE_A; we = 1'b0; end
      endcase
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
